// File: rtl/color_led_driver.sv
// color_led_driver: RGB LED PWM driver fed by the 2-bit colour-state register.
// Colour codes: 00 = off, 01 = red, 10 = blue, 11 = green.
// A colour change ramps the old channel to dark, switches channel, then ramps up.
//
// Build option: define COLOR_FADE_EN to enable the fade FSM. Without it, colour
// changes take effect at once (level jumps to MAX or 0) and busy stays 0.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst     in   1      asynchronous active-low reset
//   color   in   2      requested colour code
//   led_r   out  1      red PWM drive (registered)
//   led_g   out  1      green PWM drive (registered)
//   led_b   out  1      blue PWM drive (registered)
//   active  out  2      colour currently driven (00 = dark)
//   level   out  PWM_W  current brightness, 0..MAX
//   busy    out  1      high while a fade is in progress
module color_led_driver #(
  parameter int unsigned PWM_W     = 4,
  parameter int unsigned FADE_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       color,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic [1:0]       active,
  output logic [PWM_W-1:0] level,
  output logic             busy
);

  localparam logic [PWM_W-1:0] MAX   = {PWM_W{1'b1}};
  localparam logic [1:0]       C_OFF = 2'b00;
  localparam logic [1:0]       C_R   = 2'b01;
  localparam logic [1:0]       C_B   = 2'b10;
  localparam logic [1:0]       C_G   = 2'b11;

  // Reject step sizes that could never reach MAX or 0 sensibly.
  if (FADE_STEP < 1 || FADE_STEP > (1 << PWM_W) - 1) begin : g_step_chk
    $error("color_led_driver: FADE_STEP out of range");
  end

  logic [1:0]       color_q;
  logic [PWM_W-1:0] pwm_cnt;
  logic [1:0]       active_nxt;
  logic [PWM_W-1:0] level_nxt;
  logic             busy_nxt;

`ifdef COLOR_FADE_EN
  typedef enum logic [1:0] {HOLD, FADE_OUT, FADE_IN} state_t;

  localparam logic [PWM_W:0] STEP_W = (PWM_W+1)'(FADE_STEP);
  localparam logic [PWM_W:0] MAX_W  = {1'b0, MAX};

  state_t           state, state_nxt;
  logic             wrap;
  logic [PWM_W:0]   lvl_w;
  logic [PWM_W:0]   lvl_up_w;
  logic [PWM_W-1:0] level_dn;
  logic [PWM_W-1:0] level_up;

  assign wrap     = (pwm_cnt == MAX);
  assign lvl_w    = {1'b0, level};
  assign lvl_up_w = lvl_w + STEP_W;

  // Saturating ramp arithmetic in PWM_W+1 bits so it never wraps.
  always_comb begin
    level_dn = '0;
    level_up = MAX;
    if (lvl_w >= STEP_W) level_dn = PWM_W'(lvl_w - STEP_W);
    if (lvl_up_w <= MAX_W) level_up = PWM_W'(lvl_up_w);
  end

  // Fade FSM: next state, next active colour and next brightness.
  always_comb begin
    state_nxt  = state;
    active_nxt = active;
    level_nxt  = level;
    case (state)
      HOLD: begin
        if (color_q != active) state_nxt = FADE_OUT;
      end
      FADE_OUT: begin
        if (wrap) level_nxt = level_dn;
        // Channel may only switch while dark.
        if (level == '0) begin
          active_nxt = color_q;
          state_nxt  = (color_q == C_OFF) ? HOLD : FADE_IN;
        end else if (color_q == active) begin
          state_nxt = FADE_IN;
        end
      end
      FADE_IN: begin
        if (wrap) level_nxt = level_up;
        if (color_q != active)  state_nxt = FADE_OUT;
        else if (level == MAX)  state_nxt = HOLD;
      end
      default: state_nxt = HOLD;
    endcase
    busy_nxt = (state_nxt != HOLD);
  end
`else
  // Immediate switch: new colour and its full/zero level in one cycle.
  always_comb begin
    active_nxt = active;
    level_nxt  = level;
    busy_nxt   = 1'b0;
    if (color_q != active) begin
      active_nxt = color_q;
      level_nxt  = (color_q == C_OFF) ? '0 : MAX;
    end
  end
`endif

  // State, datapath and registered LED outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef COLOR_FADE_EN
      state   <= HOLD;
`endif
      color_q <= C_OFF;
      pwm_cnt <= '0;
      active  <= C_OFF;
      level   <= '0;
      busy    <= 1'b0;
      led_r   <= 1'b0;
      led_g   <= 1'b0;
      led_b   <= 1'b0;
    end else begin
`ifdef COLOR_FADE_EN
      state   <= state_nxt;
`endif
      color_q <= color;
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      active  <= active_nxt;
      level   <= level_nxt;
      busy    <= busy_nxt;
      led_r   <= (active == C_R) && (pwm_cnt < level);
      led_g   <= (active == C_G) && (pwm_cnt < level);
      led_b   <= (active == C_B) && (pwm_cnt < level);
    end
  end

endmodule

// File: tb/tb_color_led_driver.sv
// tb_color_led_driver: directed self-checking bench for color_led_driver
// (PWM_W=4, FADE_STEP=4). Covers the fade build when COLOR_FADE_EN is defined,
// otherwise the immediate-switch build.
module tb_color_led_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] color;
  logic       led_r, led_g, led_b;
  logic [1:0] active;
  logic [3:0] level;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_r, cnt_g, cnt_b;
  int cnt_busy = 0;

  color_led_driver #(.PWM_W(4), .FADE_STEP(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .color  (color),
    .led_r  (led_r),
    .led_g  (led_g),
    .led_b  (led_b),
    .active (active),
    .level  (level),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and accumulate LED/busy activity.
  task automatic step();
    @(negedge clk);
    cnt_r    += int'(led_r);
    cnt_g    += int'(led_g);
    cnt_b    += int'(led_b);
    cnt_busy += int'(busy);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    cnt_r = 0;
    cnt_g = 0;
    cnt_b = 0;
  endtask

  // Wait (bounded) for level to move, then check the new value.
  task automatic wait_level(input int exp, input string tag);
    int prev;
    prev = int'(level);
    for (int i = 0; i < 64; i++) begin
      step();
      if (int'(level) != prev) break;
    end
    check(tag, int'(level), exp);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_active"}, int'(active), 0);
    check({tag, "_level"},  int'(level),  0);
    check({tag, "_busy"},   int'(busy),   0);
    check({tag, "_leds"},   int'({led_r, led_g, led_b}), 0);
  endtask

  initial begin
    rst   = 1'b0;
    color = 2'b00;
    clr();
    cycles(3);
    check_dark("rst");
    rst   = 1'b1;
    color = 2'b01;

`ifdef COLOR_FADE_EN
    // Power-up ramp on red.
    wait_level(4, "up_4");
    check("up_active", int'(active), 1);
    check("up_busy", int'(busy), 1);
    wait_level(8,  "up_8");
    wait_level(12, "up_12");
    wait_level(15, "up_15");
    step();
    check("up_busy_done", int'(busy), 0);
    step();
    clr();
    cycles(16);
    check("up_duty_r", cnt_r, 15);
    check("up_duty_g", cnt_g, 0);
    check("up_duty_b", cnt_b, 0);

    // Switch red -> blue.
    color = 2'b10;
    wait_level(11, "sw_11");
    wait_level(7,  "sw_7");
    wait_level(3,  "sw_3");
    wait_level(0,  "sw_0");
    check("sw_active_at_0", int'(active), 1);
    clr();
    wait_level(4, "sw_4");
    check("sw_active_b", int'(active), 2);
    wait_level(8,  "sw_8");
    wait_level(12, "sw_12");
    wait_level(15, "sw_15");
    check("sw_no_red", cnt_r, 0);
    step();
    check("sw_busy_done", int'(busy), 0);
    step();
    clr();
    cycles(16);
    check("sw_duty_b", cnt_b, 15);
    check("sw_duty_r", cnt_r, 0);

    // Turn off from blue.
    color = 2'b00;
    wait_level(11, "off_11");
    wait_level(7,  "off_7");
    wait_level(3,  "off_3");
    wait_level(0,  "off_0");
    cycles(2);
    check("off_active", int'(active), 0);
    check("off_busy", int'(busy), 0);
    clr();
    cycles(16);
    check("off_leds", cnt_r + cnt_g + cnt_b, 0);
    check("off_level", int'(level), 0);

    // Reversal: fade red down, withdraw the request at level 7.
    color = 2'b01;
    wait_level(4,  "rv_up_4");
    wait_level(8,  "rv_up_8");
    wait_level(12, "rv_up_12");
    wait_level(15, "rv_up_15");
    cycles(2);
    color = 2'b10;
    wait_level(11, "rv_dn_11");
    wait_level(7,  "rv_dn_7");
    color = 2'b01;
    wait_level(11, "rv_in_11");
    check("rv_active_11", int'(active), 1);
    check("rv_busy_11", int'(busy), 1);
    wait_level(15, "rv_in_15");
    check("rv_active_15", int'(active), 1);
    step();
    check("rv_busy_done", int'(busy), 0);

    // Reset in the middle of a fade, colour held at red across release.
    color = 2'b10;
    wait_level(11, "mr_11");
    rst   = 1'b0;
    color = 2'b01;
    #1;
    check_dark("mr");
    step();
    rst = 1'b1;
    wait_level(4, "mr_up_4");
    check("mr_active", int'(active), 1);
    wait_level(8,  "mr_up_8");
    wait_level(12, "mr_up_12");
    wait_level(15, "mr_up_15");
`else
    // Immediate switch: two-cycle latency from the input edge.
    step();
    check("im_lat1_active", int'(active), 0);
    check("im_lat1_level", int'(level), 0);
    step();
    check("im_r_active", int'(active), 1);
    check("im_r_level", int'(level), 15);
    step();
    clr();
    cycles(16);
    check("im_duty_r", cnt_r, 15);
    check("im_duty_g", cnt_g, 0);
    check("im_duty_b", cnt_b, 0);

    color = 2'b11;
    step();
    check("im_g_lat1", int'(active), 1);
    step();
    check("im_g_active", int'(active), 3);
    check("im_g_level", int'(level), 15);
    step();
    clr();
    cycles(16);
    check("im_duty_g2", cnt_g, 15);
    check("im_duty_r2", cnt_r, 0);

    color = 2'b10;
    cycles(2);
    check("im_b_active", int'(active), 2);
    step();
    clr();
    cycles(16);
    check("im_duty_b3", cnt_b, 15);
    check("im_duty_g3", cnt_g, 0);

    color = 2'b00;
    cycles(2);
    check("im_off_active", int'(active), 0);
    check("im_off_level", int'(level), 0);
    step();
    clr();
    cycles(16);
    check("im_off_leds", cnt_r + cnt_g + cnt_b, 0);

    color = 2'b01;
    cycles(4);
    rst = 1'b0;
    #1;
    check_dark("im_rst");
    step();
    rst = 1'b1;
    check("im_busy_never", cnt_busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
